// File: rtl/switch_select_debouncer.sv
// switch_select_debouncer
// Turns the three raw active-low board switches into a clean, active-high
// 3-bit select code for the segment decoder. The pins are synchronized,
// debounced as a group, and a new code is committed only after it has held
// steady for DEBOUNCE_CYCLES synchronized samples.
//
// state  | meaning
// -------+-------------------------------------------------------------
// STABLE | synchronized sample matches the committed Select
// SETTLE | a candidate code differs from Select and is being timed
// COMMIT | candidate held long enough; Select is loaded on this cycle
module switch_select_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       SZeroInput,
    input  logic       SOneInput,
    input  logic       STwoInput,
    output logic [2:0] Select,
    output logic       SelectChanged,
    output logic       Busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Reaching this value while the candidate still matches means the next
    // increment completes the window, so COMMIT follows on the same edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

    typedef enum logic [1:0] {
        STABLE = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } stateT;

    logic [2:0]       syncChain [SYNC_STAGES];
    logic [2:0]       sample;
    stateT            state;
    stateT            nextState;
    logic [2:0]       candidate;
    logic [2:0]       nextCandidate;
    logic [2:0]       nextSelect;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] nextCounter;
    logic             nextChanged;

    // Synchronizer chain; resets to "released" so nothing looks pressed.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncChain[i] <= 3'b111;
            end
        end else begin
            syncChain[0] <= {STwoInput, SOneInput, SZeroInput};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncChain[i] <= syncChain[i-1];
            end
        end
    end

    // Pins are active-low; everything downstream works active-high.
    assign sample = ~syncChain[SYNC_STAGES-1];

    // State, candidate, counter and registered outputs.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state         <= STABLE;
            candidate     <= 3'b000;
            counter       <= '0;
            Select        <= 3'b000;
            SelectChanged <= 1'b0;
            Busy          <= 1'b0;
        end else begin
            state         <= nextState;
            candidate     <= nextCandidate;
            counter       <= nextCounter;
            Select        <= nextSelect;
            SelectChanged <= nextChanged;
            Busy          <= (nextState != STABLE);
        end
    end

    // Next-state logic: restart the window on any new value, abandon it
    // if the sample bounces back to the committed code.
    always_comb begin
        nextState     = state;
        nextCandidate = candidate;
        nextCounter   = counter;
        nextSelect    = Select;
        nextChanged   = 1'b0;
        unique case (state)
            STABLE: begin
                if (sample != Select) begin
                    nextCandidate = sample;
                    nextCounter   = CNT_ONE;
                    nextState     = SETTLE;
                end
            end
            SETTLE: begin
                if (sample == Select) begin
                    nextCounter = '0;
                    nextState   = STABLE;
                end else if (sample != candidate) begin
                    nextCandidate = sample;
                    nextCounter   = CNT_ONE;
                end else begin
                    if (counter != CNT_MAX) begin
                        nextCounter = counter + CNT_ONE;
                    end
                    if (counter >= CNT_LAST) begin
                        nextState = COMMIT;
                    end
                end
            end
            COMMIT: begin
                // Sample is deliberately ignored here; STABLE re-checks it.
                nextSelect  = candidate;
                nextChanged = 1'b1;
                nextCounter = '0;
                nextState   = STABLE;
            end
            default: begin
                nextCounter = '0;
                nextState   = STABLE;
            end
        endcase
    end

endmodule
